// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic valid/ready pipeline stage register.
//
// Sits on a pipeline boundary and holds up to two beats (SKID=1, registered in_ready) or
// one beat (SKID=0, in_ready combinational from out_ready). Supports synchronous flush,
// a global stall that freezes all state, and a squash qualifier that rewrites selected
// payload bits as the beat is captured.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active low
//   stall     in   freeze state, block both transfers
//   flush     in   drop held beats and the beat offered this cycle
//   squash    in   apply SQ_CLR/SQ_SET rewrite to the captured beat
//   in_valid  in   upstream beat valid
//   in_ready  out  stage can accept a beat
//   in_data   in   upstream payload
//   out_valid out  payload valid toward downstream
//   out_ready in   downstream accepts
//   out_data  out  head payload, zero when empty
//   count     out  number of beats held
module pipe_stage_buf #(
  parameter int unsigned          DATA_W = 64,
  parameter int unsigned          SKID   = 1,
  parameter logic [DATA_W-1:0]    SQ_CLR = '0,
  parameter logic [DATA_W-1:0]    SQ_SET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              squash,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] cap;
  state_e            state;

  // SQ_SET is applied last so it wins over SQ_CLR on overlapping bits.
  assign cap = squash ? ((in_data & ~SQ_CLR) | SQ_SET) : in_data;

  assign count = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign state = state_e'(count);

  // With the skid buffer, in_ready depends on registered state only.
  assign in_ready = (SKID != 0) ? (!stall && !skid_valid_q)
                                : (!stall && (!main_valid_q || out_ready));

  assign out_valid = main_valid_q && !stall;
  assign out_data  = main_data_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (stall) begin
      // hold everything
    end else if (SKID != 0) begin
      unique case (state)
        StEmpty: begin
          if (in_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = cap;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_data_d = cap;
          end else if (out_fire) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
          end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = cap;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          main_data_d  = '0;
          skid_valid_d = 1'b0;
          skid_data_d  = '0;
        end
      endcase
    end else begin
      if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = cap;
      end else if (out_fire) begin
        main_valid_d = 1'b0;
        main_data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam logic [63:0] SqClr = 64'h1;
  localparam logic [63:0] SqSet = 64'h8000_0000_0000_0000;

  logic clk;
  logic rst;

  // SKID=1 instance with squash rewrite
  logic        s1_stall, s1_flush, s1_squash, s1_iv, s1_ordy;
  logic [63:0] s1_id;
  logic        s1_ir, s1_ov;
  logic [63:0] s1_od;
  logic [1:0]  s1_cnt;

  // SKID=0 instance
  logic        s0_stall, s0_flush, s0_squash, s0_iv, s0_ordy;
  logic [63:0] s0_id;
  logic        s0_ir, s0_ov;
  logic [63:0] s0_od;
  logic [1:0]  s0_cnt;

  int n_checks;
  int n_fail;

  pipe_stage_buf #(
    .DATA_W (64),
    .SKID   (1),
    .SQ_CLR (SqClr),
    .SQ_SET (SqSet)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .stall     (s1_stall),
    .flush     (s1_flush),
    .squash    (s1_squash),
    .in_valid  (s1_iv),
    .in_ready  (s1_ir),
    .in_data   (s1_id),
    .out_valid (s1_ov),
    .out_ready (s1_ordy),
    .out_data  (s1_od),
    .count     (s1_cnt)
  );

  pipe_stage_buf #(
    .DATA_W (64),
    .SKID   (0),
    .SQ_CLR (64'h0),
    .SQ_SET (64'h0)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .stall     (s0_stall),
    .flush     (s0_flush),
    .squash    (s0_squash),
    .in_valid  (s0_iv),
    .in_ready  (s0_ir),
    .in_data   (s0_id),
    .out_valid (s0_ov),
    .out_ready (s0_ordy),
    .out_data  (s0_od),
    .count     (s0_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        squash;
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        chk;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_od;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NVec = 28;
  vec_t vecs[NVec];

  function automatic vec_t mk(input logic r, input logic st, input logic fl, input logic sq,
                              input logic iv, input logic [63:0] id, input logic ordy,
                              input logic chk, input logic e_ir, input logic e_ov,
                              input logic [63:0] e_od, input logic [1:0] e_cnt);
    vec_t v;
    v.rst = r; v.stall = st; v.flush = fl; v.squash = sq; v.iv = iv; v.id = id;
    v.ordy = ordy; v.chk = chk; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [63:0] q1[$];
  logic [63:0] q0[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    {s1_stall, s1_flush, s1_squash, s1_iv, s1_ordy} = '0;
    {s0_stall, s0_flush, s0_squash, s0_iv, s0_ordy} = '0;
    s1_id = '0;
    s0_id = '0;

    // Expected values are the pre-edge outputs with the row's inputs applied.
    //                rst st fl sq iv id      ordy chk ir ov od                      cnt
    vecs[0]  = mk(0, 0, 0, 0, 1, 64'hA5, 0,   0,  1, 0, 64'h0,                  2'd0);
    vecs[1]  = mk(0, 0, 0, 0, 1, 64'hA5, 0,   1,  1, 0, 64'h0,                  2'd0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 64'h0,  0,   1,  1, 0, 64'h0,                  2'd0);
    // backpressure
    vecs[3]  = mk(1, 0, 0, 0, 1, 64'h11, 0,   1,  1, 0, 64'h0,                  2'd0);
    vecs[4]  = mk(1, 0, 0, 0, 1, 64'h22, 0,   1,  1, 1, 64'h11,                 2'd1);
    vecs[5]  = mk(1, 0, 0, 0, 1, 64'h33, 0,   1,  0, 1, 64'h11,                 2'd2);
    vecs[6]  = mk(1, 0, 0, 0, 0, 64'h0,  1,   1,  0, 1, 64'h11,                 2'd2);
    vecs[7]  = mk(1, 0, 0, 0, 0, 64'h0,  1,   1,  1, 1, 64'h22,                 2'd1);
    vecs[8]  = mk(1, 0, 0, 0, 0, 64'h0,  0,   1,  1, 0, 64'h0,                  2'd0);
    // squash
    vecs[9]  = mk(1, 0, 0, 1, 1, 64'h0F, 0,   1,  1, 0, 64'h0,                  2'd0);
    vecs[10] = mk(1, 0, 0, 0, 0, 64'h0,  1,   1,  1, 1, 64'h8000_0000_0000_000E, 2'd1);
    vecs[11] = mk(1, 0, 0, 0, 0, 64'h0,  0,   1,  1, 0, 64'h0,                  2'd0);
    // flush beats stall while full
    vecs[12] = mk(1, 0, 0, 0, 1, 64'hA1, 0,   1,  1, 0, 64'h0,                  2'd0);
    vecs[13] = mk(1, 0, 0, 0, 1, 64'hA2, 0,   1,  1, 1, 64'hA1,                 2'd1);
    vecs[14] = mk(1, 1, 1, 0, 1, 64'hA3, 1,   1,  0, 0, 64'hA1,                 2'd2);
    vecs[15] = mk(1, 0, 0, 0, 0, 64'h0,  0,   1,  1, 0, 64'h0,                  2'd0);
    // stall alone for 5 cycles while full
    vecs[16] = mk(1, 0, 0, 0, 1, 64'hB1, 0,   1,  1, 0, 64'h0,                  2'd0);
    vecs[17] = mk(1, 0, 0, 0, 1, 64'hB2, 0,   1,  1, 1, 64'hB1,                 2'd1);
    for (int i = 18; i < 23; i++)
      vecs[i] = mk(1, 1, 0, 0, 1, 64'hCC, 1,  1,  0, 0, 64'hB1,                 2'd2);
    vecs[23] = mk(1, 0, 0, 0, 0, 64'h0,  1,   1,  0, 1, 64'hB1,                 2'd2);
    vecs[24] = mk(1, 0, 0, 0, 0, 64'h0,  1,   1,  1, 1, 64'hB2,                 2'd1);
    vecs[25] = mk(1, 0, 0, 0, 0, 64'h0,  0,   1,  1, 0, 64'h0,                  2'd0);
    // flush coinciding with in_fire drops the beat
    vecs[26] = mk(1, 0, 1, 0, 1, 64'hDD, 0,   1,  1, 0, 64'h0,                  2'd0);
    vecs[27] = mk(1, 0, 0, 0, 0, 64'h0,  0,   1,  1, 0, 64'h0,                  2'd0);

    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      s1_stall  = vecs[i].stall;
      s1_flush  = vecs[i].flush;
      s1_squash = vecs[i].squash;
      s1_iv     = vecs[i].iv;
      s1_id     = vecs[i].id;
      s1_ordy   = vecs[i].ordy;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d in_ready", i),  {63'h0, s1_ir},  {63'h0, vecs[i].e_ir});
        check($sformatf("v%0d out_valid", i), {63'h0, s1_ov},  {63'h0, vecs[i].e_ov});
        check($sformatf("v%0d out_data", i),  s1_od,           vecs[i].e_od);
        check($sformatf("v%0d count", i),     {62'h0, s1_cnt}, {62'h0, vecs[i].e_cnt});
      end
    end

    // Streaming through both variants: 8 back-to-back beats with out_ready held high.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      s1_stall = 0; s1_flush = 0; s1_squash = 0; s1_ordy = 1;
      s0_stall = 0; s0_flush = 0; s0_squash = 0; s0_ordy = 1;
      s1_iv = (k < 8);
      s0_iv = (k < 8);
      s1_id = 64'(k);
      s0_id = 64'(k);
      if (k < 8) begin
        q1.push_back(64'(k));
        q0.push_back(64'(k));
      end
      #1;
      if (k < 8) begin
        check($sformatf("s1 k%0d in_ready", k), {63'h0, s1_ir}, 64'h1);
        check($sformatf("s0 k%0d in_ready", k), {63'h0, s0_ir}, 64'h1);
      end
      check($sformatf("s1 k%0d out_valid", k), {63'h0, s1_ov}, {63'h0, (k >= 1 && k <= 8)});
      check($sformatf("s0 k%0d out_valid", k), {63'h0, s0_ov}, {63'h0, (k >= 1 && k <= 8)});
      check($sformatf("s1 k%0d count", k), {62'h0, s1_cnt}, (k >= 1 && k <= 8) ? 64'h1 : 64'h0);
      check($sformatf("s0 k%0d count", k), {62'h0, s0_cnt}, (k >= 1 && k <= 8) ? 64'h1 : 64'h0);
      if (s1_ov && s1_ordy && q1.size() > 0)
        check($sformatf("s1 k%0d out_data", k), s1_od, q1.pop_front());
      if (s0_ov && s0_ordy && q0.size() > 0)
        check($sformatf("s0 k%0d out_data", k), s0_od, q0.pop_front());
    end
    check("s1 scoreboard drained", 64'(q1.size()), 64'h0);
    check("s0 scoreboard drained", 64'(q0.size()), 64'h0);

    // SKID=0: full stage with out_ready low refuses; raising out_ready re-opens in_ready
    // combinationally.
    @(negedge clk);
    s0_iv = 1; s0_id = 64'h55; s0_ordy = 0;
    #1;
    check("s0 hold ir0", {63'h0, s0_ir}, 64'h1);
    @(negedge clk);
    s0_iv = 1; s0_id = 64'h66; s0_ordy = 0;
    #1;
    check("s0 full in_ready", {63'h0, s0_ir}, 64'h0);
    check("s0 full out_data", s0_od, 64'h55);
    check("s0 full count", {62'h0, s0_cnt}, 64'h1);
    @(negedge clk);
    s0_ordy = 1;
    #1;
    check("s0 comb in_ready", {63'h0, s0_ir}, 64'h1);
    check("s0 held out_data", s0_od, 64'h55);
    @(negedge clk);
    s0_iv = 0; s0_ordy = 1;
    #1;
    check("s0 next out_data", s0_od, 64'h66);
    @(negedge clk);
    #1;
    check("s0 drained count", {62'h0, s0_cnt}, 64'h0);
    check("s0 drained out_data", s0_od, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
